// File: rtl/run_ctrl_monitor_if.sv
// Run-controller bundle: run start, core writeback observation, and run results/status.
// Trace read ports exist only when RUN_CTRL_TRACE_EN is defined.
interface run_ctrl_monitor_if #(
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned STATE_W = 5,
  parameter int unsigned CNT_W   = 16
`ifdef RUN_CTRL_TRACE_EN
  , parameter int unsigned TRACE_DEPTH = 8
`endif
);

  logic               start;
  logic [STATE_W-1:0] state_in;
  logic               wb_valid;
  logic [DATA_W-1:0]  wb_data;

  logic               core_rst;
  logic               running;
  logic               done;
  logic [1:0]         status;
  logic [CNT_W-1:0]   cycle_count;
  logic [CNT_W-1:0]   wb_count;
  logic [DATA_W-1:0]  signature;

`ifdef RUN_CTRL_TRACE_EN
  localparam int unsigned TRACE_AW = (TRACE_DEPTH > 1) ? $clog2(TRACE_DEPTH) : 1;

  logic [TRACE_AW-1:0] trace_rd_idx;
  logic [DATA_W-1:0]   trace_rd_data;

  modport master (
    output start, state_in, wb_valid, wb_data, trace_rd_idx,
    input  core_rst, running, done, status, cycle_count, wb_count, signature, trace_rd_data
  );

  modport slave (
    input  start, state_in, wb_valid, wb_data, trace_rd_idx,
    output core_rst, running, done, status, cycle_count, wb_count, signature, trace_rd_data
  );
`else
  modport master (
    output start, state_in, wb_valid, wb_data,
    input  core_rst, running, done, status, cycle_count, wb_count, signature
  );

  modport slave (
    input  start, state_in, wb_valid, wb_data,
    output core_rst, running, done, status, cycle_count, wb_count, signature
  );
`endif

endinterface

// File: rtl/run_ctrl_monitor.sv
// Run controller and execution monitor for the multicycle core: reset sequencing, cycle budget,
// halt/hang detection, writeback signature. Optional trace ring enabled by RUN_CTRL_TRACE_EN.
module run_ctrl_monitor #(
  parameter int unsigned DATA_W      = 64,
  parameter int unsigned STATE_W     = 5,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned MAX_CYCLES  = 64,
  parameter int unsigned RST_CYCLES  = 2,
  parameter int unsigned HALT_STATE  = 31,
  parameter int unsigned HALT_HOLD   = 2,
  parameter int unsigned WDOG_CYCLES = 16
`ifdef RUN_CTRL_TRACE_EN
  , parameter int unsigned TRACE_DEPTH = 8
`endif
) (
  input logic               clk,
  input logic               rst,
  run_ctrl_monitor_if.slave bus
);

  localparam int unsigned RCNT_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RESET,
    S_RUN,
    S_DONE
  } state_t;

  state_t             state;
  state_t             next_state;
  logic [RCNT_W-1:0]  rst_cnt;
  logic [CNT_W-1:0]   hold_cnt;
  logic [CNT_W-1:0]   wdog_cnt;

  logic               take_start;
  logic [CNT_W-1:0]   cyc_inc;
  logic [CNT_W-1:0]   hold_inc;
  logic [CNT_W-1:0]   wdog_inc;
  logic               halt_fire;
  logic               limit_fire;
  logic               wdog_fire;
  logic [1:0]         fire_status;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  // Next state plus the end-of-run detectors evaluated on this RUN cycle's inputs
  always_comb begin
    next_state  = state;
    take_start  = 1'b0;
    cyc_inc     = bus.cycle_count + CNT_W'(1);
    hold_inc    = (bus.state_in == STATE_W'(HALT_STATE)) ? hold_cnt + CNT_W'(1) : '0;
    wdog_inc    = bus.wb_valid ? '0 : wdog_cnt + CNT_W'(1);
    halt_fire   = (hold_inc == CNT_W'(HALT_HOLD));
    limit_fire  = (cyc_inc == CNT_W'(MAX_CYCLES));
    wdog_fire   = (WDOG_CYCLES != 0) && (wdog_inc == CNT_W'(WDOG_CYCLES));
    fire_status = halt_fire  ? 2'b01 :
                  limit_fire ? 2'b10 :
                  wdog_fire  ? 2'b11 : 2'b00;
    case (state)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          take_start = 1'b1;
          next_state = S_RESET;
        end
      end
      S_RESET: if (rst_cnt == RCNT_W'(RST_CYCLES - 1)) next_state = S_RUN;
      S_RUN:   if (fire_status != 2'b00) next_state = S_DONE;
      default: next_state = S_IDLE;
    endcase
  end

  // Control outputs registered from the next state so they align with the state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.core_rst <= 1'b1;
      bus.running  <= 1'b0;
      bus.done     <= 1'b0;
    end else begin
      bus.core_rst <= (next_state != S_RUN);
      bus.running  <= (next_state == S_RUN);
      bus.done     <= (next_state == S_DONE);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rst_cnt         <= '0;
      hold_cnt        <= '0;
      wdog_cnt        <= '0;
      bus.cycle_count <= '0;
      bus.wb_count    <= '0;
      bus.signature   <= '0;
      bus.status      <= 2'b00;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (take_start) begin
            rst_cnt         <= '0;
            hold_cnt        <= '0;
            wdog_cnt        <= '0;
            bus.cycle_count <= '0;
            bus.wb_count    <= '0;
            bus.signature   <= '0;
            bus.status      <= 2'b00;
          end
        end
        S_RESET: rst_cnt <= rst_cnt + RCNT_W'(1);
        S_RUN: begin
          bus.cycle_count <= cyc_inc;
          hold_cnt        <= hold_inc;
          wdog_cnt        <= wdog_inc;
          if (bus.wb_valid) begin
            if (bus.wb_count != '1) bus.wb_count <= bus.wb_count + CNT_W'(1);
            bus.signature <= {bus.signature[DATA_W-2:0], bus.signature[DATA_W-1]} ^ bus.wb_data;
          end
          if (fire_status != 2'b00) bus.status <= fire_status;
        end
        default: ;
      endcase
    end
  end

`ifdef RUN_CTRL_TRACE_EN
  localparam int unsigned TRACE_AW = (TRACE_DEPTH > 1) ? $clog2(TRACE_DEPTH) : 1;

  logic [DATA_W-1:0]   ring [TRACE_DEPTH];
  logic [TRACE_AW-1:0] wptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                 wptr <= '0;
    else if (take_start)                     wptr <= '0;
    else if (state == S_RUN && bus.wb_valid) wptr <= wptr + TRACE_AW'(1);
  end

  // Ring contents survive reset; only the pointer is cleared
  always_ff @(posedge clk) begin
    if (state == S_RUN && bus.wb_valid) ring[wptr] <= bus.wb_data;
  end

  assign bus.trace_rd_data = ring[TRACE_AW'(wptr + bus.trace_rd_idx)];
`endif

endmodule

// File: doc/run_ctrl_monitor.md
Name: run_ctrl_monitor

Overview:
Parametrised run controller and execution monitor for the multicycle RISC-V core. It sequences the core reset, bounds the run by a cycle budget, and detects halt (FSM parked in a halt state) and hang (no register writeback for too long). It also accumulates a writeback signature and counts writebacks. Synthesisable; sits beside `principal`, in benches and in on-FPGA self-test wrappers.

Parameters:
- DATA_W, 64, writeback data width.
- STATE_W, 5, width of the core FSM state code.
- CNT_W, 16, width of the cycle and writeback counters.
- MAX_CYCLES, 64, RUN-cycle budget (1..2^CNT_W-1).
- RST_CYCLES, 2, core reset pulse length in clocks (>=1).
- HALT_STATE, 31, state code that means halted.
- HALT_HOLD, 2, consecutive RUN cycles in HALT_STATE needed to declare halt (>=1).
- WDOG_CYCLES, 16, consecutive RUN cycles without writeback that trip the watchdog; 0 disables it.
- TRACE_DEPTH, 8, trace ring depth (power of 2); used only with TRACE_EN.

Ports:
- clk, in, 1, clock.
- rst, in, 1, asynchronous active-high reset.
- start, in, 1, single-cycle pulse that starts a run.
- state_in, in, STATE_W, core FSM state code.
- wb_valid, in, 1, core register-bank write enable.
- wb_data, in, DATA_W, core register-bank write data.
- core_rst, out, 1, reset driven to the core.
- running, out, 1, high while in RUN.
- done, out, 1, high while in DONE.
- status, out, 2, end cause: 00 none, 01 halted, 10 cycle limit, 11 watchdog.
- cycle_count, out, CNT_W, RUN cycles elapsed.
- wb_count, out, CNT_W, writebacks seen in RUN; saturates at all-ones.
- signature, out, DATA_W, writeback checksum.
- trace_rd_idx, in, log2(TRACE_DEPTH), trace read index; TRACE_EN only.
- trace_rd_data, out, DATA_W, trace read data; TRACE_EN only.

Behaviour:
- Reset is asynchronous. It sets the FSM to IDLE, core_rst=1, running=0, done=0, status=00, and all counters and signature to 0.
- FSM states:
  - IDLE: core_rst=1. A start sampled at a clock edge moves the FSM to RESET.
  - RESET: core_rst=1 for exactly RST_CYCLES clocks, then RUN. On entry, cycle_count, wb_count, signature, status, the halt-hold counter, the watchdog counter and the trace pointer are cleared.
  - RUN: core_rst=0, running=1.
    - cycle_count increments every RUN cycle.
    - On wb_valid: wb_count++ (saturating) and signature <= rotl1(signature) XOR wb_data.
    - The halt-hold counter increments while state_in==HALT_STATE and clears otherwise; halt fires when it reaches HALT_HOLD.
    - The watchdog counter clears on wb_valid and increments otherwise; it fires when it reaches WDOG_CYCLES (only if WDOG_CYCLES != 0).
    - The limit fires when cycle_count reaches MAX_CYCLES.
    - On any fire: move to DONE at the next edge and latch status.
  - DONE: core_rst=1 (core frozen), done=1, running=0. Counters and signature hold. A start here moves to RESET (rerun).
- Simultaneous fire priority: halt (01) > limit (10) > watchdog (11).
- Inputs are ignored outside RUN. start is ignored in RESET and RUN.
- The writeback on the final RUN cycle is counted.
- cycle_count on limit equals MAX_CYCLES exactly.
- Asynchronous reset mid-RUN returns to IDLE immediately, with core_rst high combinationally from the flop reset.

Optional Feature:
- RUN_CTRL_TRACE_EN defined:
  - A TRACE_DEPTH x DATA_W ring stores wb_data on every RUN writeback.
  - The write pointer wraps, overwriting the oldest entry.
  - trace_rd_data = ring[(wptr + trace_rd_idx) mod TRACE_DEPTH] combinationally, so idx 0 is the oldest entry once wrapped.
  - Contents are not cleared by reset; the pointer is.
- Undefined: trace ports are absent and the ring is not instantiated.

Test Plan:
- Defaults. rst, then start. Expect core_rst high for 2 clocks, then running=1. With state_in never 31 and wb_valid pulsing every 4 cycles: done=1, status=10, cycle_count=64, wb_count=16.
- Hold state_in=31 from RUN cycle 10 on. Expect halt at cycle 11, status=01, cycle_count=11. A one-cycle excursion to 31 never halts.
- No wb_valid for 16 RUN cycles. Expect status=11, cycle_count=16. Repeat with WDOG_CYCLES=0: expect status=10.
- Writebacks 0x1 then 0x3. Expect signature=0x1 and wb_count=2. A second start from DONE clears both to 0 during RESET.
- MAX_CYCLES=4 with state_in=31 and HALT_HOLD=4. Halt and limit fire on the same cycle; expect status=01. Assert rst at RUN cycle 2 of another run: expect immediate IDLE, core_rst=1, counters 0.
- TRACE_EN with TRACE_DEPTH=8, 10 writebacks of values 1..10. Expect trace_rd_idx 0 -> 3 and idx 7 -> 10.
